controle_robo: RTL

- Sequencer for the map/robot memory block (10x20 map, robot row/col/orientation).
- Samples its four sensor outputs (head, left, under, barrier) and issues one-cycle avancar/girar/remover command pulses.
- Runs a left-hand wall-following walk that clears removable barriers and stops when the robot stands on the exit cell.
- Sits between the top-level start/stop control and the map block; the only master of that block's command inputs.

---
 rtl/pacote_robo.sv | 35 +++
 rtl/temporizador_espera.sv | 28 ++
 rtl/controle_robo.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pacote_robo.sv
// rtl/pacote_robo.sv - shared states, sensor bundle and map constants for the robot sequencer
package pacote_robo;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SENSE   = 4'd1,
    S_REMOVE  = 4'd2,
    S_TURN_L  = 4'd3,
    S_TURN_R  = 4'd4,
    S_ADVANCE = 4'd5,
    S_WAIT    = 4'd6,
    S_DONE    = 4'd7,
    S_ERRO    = 4'd8
  } estado_t;

  typedef struct packed {
    logic head;
    logic left;
    logic under;
    logic barrier;
  } sensores_t;

  // Orientation runs clockwise, the same direction one girar pulse rotates.
  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] E = 2'd1;
  localparam logic [1:0] S = 2'd2;
  localparam logic [1:0] W = 2'd3;

  localparam int ROWS = 10;
  localparam int COLS = 20;

  // A left turn is three clockwise quarter turns.
  localparam logic [1:0] TURNS_LEFT = 2'd3;

endpackage

// File: rtl/temporizador_espera.sv
// rtl/temporizador_espera.sv - settle down-counter, expired once SETTLE wait cycles have elapsed
module temporizador_espera #(
  parameter int SETTLE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] r_count;

  // Loaded during the command cycle, so the first wait cycle already sees SETTLE-1 remaining.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= CW'(SETTLE - 1);
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/controle_robo.sv
// rtl/controle_robo.sv - left-hand wall-following sequencer; CONTROLE_STEP_LIMIT_EN enables the advance limit
module controle_robo
  import pacote_robo::*;
#(
  parameter int SETTLE    = 1,
  parameter int STEP_W    = 10,
  parameter int MAX_STEPS = 200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              parar,
  input  logic              head_in,
  input  logic              left_in,
  input  logic              under_in,
  input  logic              barrier_in,
  output logic              avancar,
  output logic              girar,
  output logic              remover,
  output logic              busy,
  output logic              done,
  output logic              erro,
  output logic [STEP_W-1:0] step_count,
  output logic [3:0]        estado
);

  estado_t           r_state;
  estado_t           w_next;
  logic [STEP_W-1:0] r_step;
  logic [1:0]        r_turn;
  logic              r_adv;
  logic              r_avancar;
  logic              r_girar;
  logic              r_remover;
  logic              w_load;
  logic              w_expired;
  logic              w_rest;
  sensores_t         w_sens;

  assign w_sens = {head_in, left_in, under_in, barrier_in};
  assign w_rest = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERRO);
  assign w_load = (r_state == S_REMOVE) || (r_state == S_ADVANCE) ||
                  (r_state == S_TURN_R) || (r_state == S_TURN_L);

`ifdef CONTROLE_STEP_LIMIT_EN
  localparam logic [STEP_W-1:0] W_MAX = STEP_W'(MAX_STEPS);
`else
  logic w_unused_max;
  assign w_unused_max = (MAX_STEPS != 0);
`endif

  temporizador_espera #(.SETTLE(SETTLE)) u_espera (
    .clock   (clock),
    .reset   (reset),
    .load    (w_load),
    .expired (w_expired)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERRO: begin
        if (start) w_next = S_SENSE;
      end
      S_SENSE: begin
        if (w_sens.under) w_next = S_DONE;
`ifdef CONTROLE_STEP_LIMIT_EN
        else if (r_step == W_MAX) w_next = S_ERRO;
`endif
        else if (w_sens.barrier) w_next = S_REMOVE;
        // After a completed left turn the robot must step into the opening it turned toward.
        else if (r_adv) w_next = w_sens.head ? S_TURN_R : S_ADVANCE;
        else if (!w_sens.left) w_next = S_TURN_L;
        else if (!w_sens.head) w_next = S_ADVANCE;
        else w_next = S_TURN_R;
      end
      S_REMOVE, S_ADVANCE, S_TURN_R, S_TURN_L: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_expired) begin
          w_next = (r_turn != 2'd0 && r_turn != TURNS_LEFT) ? S_TURN_L : S_SENSE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (parar) w_next = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_step    <= '0;
      r_turn    <= 2'd0;
      r_adv     <= 1'b0;
      r_avancar <= 1'b0;
      r_girar   <= 1'b0;
      r_remover <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_avancar <= (w_next == S_ADVANCE);
      r_girar   <= (w_next == S_TURN_L) || (w_next == S_TURN_R);
      r_remover <= (w_next == S_REMOVE);
      if (w_rest && w_next == S_SENSE) begin
        r_step <= '0;
        r_turn <= 2'd0;
        r_adv  <= 1'b0;
      end else begin
        if (r_avancar && r_step != '1) r_step <= r_step + STEP_W'(1);
        if (w_next == S_IDLE) begin
          r_turn <= 2'd0;
        end else if (r_state == S_TURN_L) begin
          r_turn <= r_turn + 2'd1;
        end else if (r_state == S_WAIT && w_next == S_SENSE && r_turn == TURNS_LEFT) begin
          r_turn <= 2'd0;
          r_adv  <= 1'b1;
        end
        if (r_state == S_SENSE && r_adv && (w_next == S_ADVANCE || w_next == S_TURN_R)) begin
          r_adv <= 1'b0;
        end
      end
    end
  end

  assign avancar    = r_avancar;
  assign girar      = r_girar;
  assign remover    = r_remover;
  assign busy       = !w_rest;
  assign done       = (r_state == S_DONE);
  assign step_count = r_step;
  assign estado     = r_state;

`ifdef CONTROLE_STEP_LIMIT_EN
  assign erro = (r_state == S_ERRO);
`else
  assign erro = 1'b0;
`endif

endmodule
